// File: rtl/data_mem_arbiter_if.sv
// Request/grant bus between two requesters, the arbiter and data_mem.
// The arbiter takes the slave view; requesters and data_mem take the master view.
interface data_mem_arbiter_if #(
  parameter int width = 32
);
  logic             m0_req;
  logic             m0_we;
  logic             m0_lock;
  logic [width-1:0] m0_addr;
  logic [width-1:0] m0_wdata;
  logic             m0_gnt;
  logic             m0_rvalid;
  logic [width-1:0] m0_rdata;

  logic             m1_req;
  logic             m1_we;
  logic             m1_lock;
  logic [width-1:0] m1_addr;
  logic [width-1:0] m1_wdata;
  logic             m1_gnt;
  logic             m1_rvalid;
  logic [width-1:0] m1_rdata;

  logic [width-1:0] mem_A;
  logic [width-1:0] mem_WD;
  logic             mem_WE;
  logic [width-1:0] mem_RD;

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_A, mem_WD, mem_WE,
    input  mem_RD
  );

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_A, mem_WD, mem_WE,
    output mem_RD
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-master round-robin arbiter with locked bursts for single-port data_mem; 1-cycle read return.
// Optional burst-length cap on locked ownership: define DMEM_ARB_LOCK_LIMIT_EN.
module data_mem_arbiter #(
  parameter int width    = 32,
  parameter int depth    = 256,
  parameter int LOCK_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  data_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             gnt0, gnt1;
  logic             limit_hit;
  logic             rvalid0_q, rvalid1_q;
  logic [width-1:0] rdata0_q, rdata1_q;

`ifdef DMEM_ARB_LOCK_LIMIT_EN
  logic [3:0] cnt_q, cnt_d;

  // Owner is on its last allowed transfer and the other master is waiting.
  always_comb begin
    limit_hit = 1'b0;
    if (state_q != IDLE && (32'(cnt_q) + 32'd1) >= 32'(LOCK_MAX))
      limit_hit = (state_q == OWN0) ? bus.m1_req : bus.m0_req;
  end

  always_comb begin
    cnt_d = 4'd0;
    if (state_q == IDLE) begin
      if ((gnt0 && bus.m0_lock) || (gnt1 && bus.m1_lock))
        cnt_d = 4'd1;
    end else if (gnt0 || gnt1) begin
      cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 4'd0;
    else     cnt_q <= cnt_d;
  end
`else
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (bus.m0_req && (!bus.m1_req || last_q)) gnt0 = 1'b1;
          else if (bus.m1_req)                        gnt1 = 1'b1;
        end
        OWN0:    gnt0 = bus.m0_req;
        OWN1:    gnt1 = bus.m1_req;
        default: ;
      endcase
    end
    // No transfer (idle, or owner dropped req) always lands in IDLE.
    if (gnt0) begin
      last_d  = 1'b0;
      state_d = (bus.m0_lock && !limit_hit) ? OWN0 : IDLE;
    end else if (gnt1) begin
      last_d  = 1'b1;
      state_d = (bus.m1_lock && !limit_hit) ? OWN1 : IDLE;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      rvalid0_q <= gnt0 && !bus.m0_we;
      rvalid1_q <= gnt1 && !bus.m1_we;
      if (gnt0 && !bus.m0_we) rdata0_q <= bus.mem_RD;
      if (gnt1 && !bus.m1_we) rdata1_q <= bus.mem_RD;
    end
  end

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rvalid = rvalid0_q;
  assign bus.m1_rvalid = rvalid1_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;

  assign bus.mem_A  = gnt0 ? bus.m0_addr  : (gnt1 ? bus.m1_addr  : '0);
  assign bus.mem_WD = gnt0 ? bus.m0_wdata : (gnt1 ? bus.m1_wdata : '0);
  assign bus.mem_WE = (gnt0 && bus.m0_we) || (gnt1 && bus.m1_we);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus random traffic against a rule-level model.
module tb_data_mem_arbiter;

`ifdef DMEM_ARB_LOCK_LIMIT_EN
  localparam int LMAX = 4;
`else
  localparam int LMAX = 8;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.width(32)) bus();

  data_mem_arbiter #(.width(32), .depth(256), .LOCK_MAX(LMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // data_mem: async read, write on clk
  logic [31:0] dmem [256];
  assign bus.mem_RD = dmem[bus.mem_A[7:0]];
  always @(posedge clk) if (bus.mem_WE) dmem[bus.mem_A[7:0]] <= bus.mem_WD;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          owner = -1;
  bit          last  = 1'b1;
  int          burst = 0;
  logic [31:0] mmem [256];
  bit          mrv [2];
  logic [31:0] mrd [2];
  logic        g0_seen, g1_seen, we_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int m, input bit req, input bit we, input bit lock,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (m == 0) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_lock = lock; bus.m0_addr = addr; bus.m0_wdata = wd;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_lock = lock; bus.m1_addr = addr; bus.m1_wdata = wd;
    end
  endtask

  // One clock: check all outputs against the model, cross the edge, advance the model.
  task automatic tick();
    bit          req[2], we[2], lk[2];
    logic [31:0] ad[2], wd[2];
    int          g;
    #1;
    req[0] = bus.m0_req; we[0] = bus.m0_we; lk[0] = bus.m0_lock; ad[0] = bus.m0_addr; wd[0] = bus.m0_wdata;
    req[1] = bus.m1_req; we[1] = bus.m1_we; lk[1] = bus.m1_lock; ad[1] = bus.m1_addr; wd[1] = bus.m1_wdata;
    g = -1;
    if (!rst) begin
      if (owner >= 0)          g = req[owner] ? owner : -1;
      else if (req[0] && req[1]) g = last ? 0 : 1;
      else if (req[0])         g = 0;
      else if (req[1])         g = 1;
    end
    check("m0_gnt", {31'b0, bus.m0_gnt}, {31'b0, g == 0});
    check("m1_gnt", {31'b0, bus.m1_gnt}, {31'b0, g == 1});
    check("mem_A",  bus.mem_A,  (g >= 0) ? ad[g] : 32'h0);
    check("mem_WD", bus.mem_WD, (g >= 0) ? wd[g] : 32'h0);
    check("mem_WE", {31'b0, bus.mem_WE}, {31'b0, (g >= 0) && we[g]});
    check("m0_rvalid", {31'b0, bus.m0_rvalid}, {31'b0, mrv[0]});
    check("m1_rvalid", {31'b0, bus.m1_rvalid}, {31'b0, mrv[1]});
    check("m0_rdata", bus.m0_rdata, mrd[0]);
    check("m1_rdata", bus.m1_rdata, mrd[1]);
    g0_seen = bus.m0_gnt; g1_seen = bus.m1_gnt; we_seen = bus.mem_WE;
    @(posedge clk);
    if (rst) begin
      owner = -1; last = 1'b1; burst = 0;
      mrv[0] = 0; mrv[1] = 0; mrd[0] = '0; mrd[1] = '0;
    end else begin
      mrv[0] = 0; mrv[1] = 0;
      if (g >= 0) begin
        if (we[g]) mmem[ad[g][7:0]] = wd[g];
        else begin mrd[g] = mmem[ad[g][7:0]]; mrv[g] = 1; end
        burst = (owner >= 0) ? burst + 1 : 1;
        if (burst > 15) burst = 15;
        last = (g == 1);
`ifdef DMEM_ARB_LOCK_LIMIT_EN
        if (owner == g && burst >= LMAX && req[1-g]) owner = -1;
        else owner = lk[g] ? g : -1;
`else
        owner = lk[g] ? g : -1;
`endif
      end else begin
        owner = -1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_both();
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin dmem[i] = '0; mmem[i] = '0; end
    mrv[0] = 0; mrv[1] = 0; mrd[0] = '0; mrd[1] = '0;
    rst = 1'b1;
    set_m(0, 1, 1, 0, 32'd4, 32'h1234);
    set_m(1, 1, 1, 0, 32'd5, 32'h5678);
    @(negedge clk);
    tick();                       // reset with requests: no grant, no write
    check("rst_no_we", {31'b0, we_seen}, 32'd0);
    tick();
    rst = 1'b0;
    idle_both();

    // 1: write then read back
    set_m(0, 1, 1, 0, 32'd4, 32'hDEAD);
    tick();
    check("t1_we", {31'b0, we_seen}, 32'd1);
    set_m(0, 1, 0, 0, 32'd4, 32'h0);
    tick();
    idle_both();
    check("t1_rvalid", {31'b0, bus.m0_rvalid}, 32'd1);
    check("t1_rdata", bus.m0_rdata, 32'hDEAD);
    tick();
    check("t1_rvalid_pulse", {31'b0, bus.m0_rvalid}, 32'd0);

    // 2: round-robin after reset, first grant to m0
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_m(0, 1, 0, 0, 32'(i), 0);
      set_m(1, 1, 0, 0, 32'(i + 8), 0);
      tick();
      check("t2_g0", {31'b0, g0_seen}, {31'b0, (i % 2) == 0});
      check("t2_g1", {31'b0, g1_seen}, {31'b0, (i % 2) == 1});
    end

    // 3: m1 locked burst of 5 writes, m0 waiting
    idle_both();
    for (int i = 0; i < 5; i++) begin
      set_m(1, 1, 1, i < 4, 32'(10 + i), 32'hA0 + 32'(i));
      set_m(0, i > 0, 0, 0, 32'd4, 0);
      tick();
`ifndef DMEM_ARB_LOCK_LIMIT_EN
      check("t3_m0_held", {31'b0, g0_seen}, 32'd0);
      check("t3_m1_gnt", {31'b0, g1_seen}, 32'd1);
`endif
    end
    set_m(1, 0, 0, 0, 0, 0);
    tick();
    check("t3_m0_after", {31'b0, g0_seen}, 32'd1);

    // 4: owner drops req in OWN0
    set_m(0, 1, 1, 1, 32'd30, 32'h77);
    tick();
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 1, 0, 0, 32'd30, 0);
    tick();
    check("t4_no_gnt", {30'b0, g1_seen, g0_seen}, 32'd0);
    tick();
    check("t4_m1_gnt", {31'b0, g1_seen}, 32'd1);

    // 5: reset mid-burst during an m0 write
    idle_both();
    set_m(0, 1, 1, 1, 32'd20, 32'h1111);
    tick();
    set_m(0, 1, 1, 1, 32'd20, 32'h2222);
    rst = 1'b1;
    tick();
    check("t5_we_in_rst", {31'b0, we_seen}, 32'd0);
    rst = 1'b0;
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 1, 0, 0, 32'd20, 0);
    #1;
    check("t5_mem_kept", dmem[20], 32'h1111);
    check("t5_rvalid", {31'b0, bus.m0_rvalid}, 32'd0);
    tick();
    check("t5_idle_m1_gnt", {31'b0, g1_seen}, 32'd1);

`ifdef DMEM_ARB_LOCK_LIMIT_EN
    // 6: lock limit hands over after LOCK_MAX owner transfers
    idle_both();
    rst = 1'b1; tick(); rst = 1'b0;
    set_m(0, 1, 1, 1, 32'd40, 32'h55);
    set_m(1, 1, 0, 0, 32'd41, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (g1_seen) break;
      if (g0_seen) n++;
    end
    check("t6_m1_after_n", {31'b0, g1_seen}, 32'd1);
    check("t6_count", 32'(n), 32'(LMAX));
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(49) == 0);
      set_m(0, $urandom_range(3) != 0, $urandom_range(1), $urandom_range(2) == 0,
            32'($urandom_range(15)), $urandom);
      set_m(1, $urandom_range(3) != 0, $urandom_range(1), $urandom_range(2) == 0,
            32'($urandom_range(15)), $urandom);
      tick();
    end
    rst = 1'b0;
    idle_both();
    tick();
    for (int i = 0; i < 16; i++) check("mem_final", dmem[i], mmem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
